// File: rtl/fr_normalize_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fr_normalize_pipe
//  Purpose  : Two-stage valid/ready leading-one detector and mantissa/exponent
//             normaliser feeding the rounding/pack stage of the FP MAC.
//  Options  : FR_NORM_FTZ_EN - flush-to-zero on exponent underflow
//             (when undefined the exponent wraps and underflow is tied low).
//  Revision : 1.0 - initial release
// ============================================================================
module fr_normalize_pipe #(
    parameter int WIDTH   = 24,
    parameter int COUNT_W = 8,
    parameter int EXP_W   = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_mant,
    input  logic [EXP_W-1:0]   in_exp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] count,
    output logic               zero,
    output logic [WIDTH-1:0]   norm_mant,
    output logic [EXP_W-1:0]   norm_exp,
    output logic               underflow
);

    localparam logic [COUNT_W-1:0] c_MSB_IDX = COUNT_W'(WIDTH - 1);
`ifdef FR_NORM_FTZ_EN
    localparam int c_CMP_W = ((EXP_W > COUNT_W) ? EXP_W : COUNT_W) + 1;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic                 w_s2_adv;
    logic                 w_s1_adv;

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_mant;
    logic [EXP_W-1:0]     r_s1_exp;
    logic [COUNT_W-1:0]   r_s1_pos;
    logic                 r_s1_zero;

    logic [COUNT_W-1:0]   w_lead_pos;
    logic                 w_in_zero;

    logic [COUNT_W-1:0]   w_shift;
    logic [WIDTH-1:0]     w_shifted;
    logic [EXP_W-1:0]     w_exp_adj;

    logic                 r_out_valid;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_zero;
    logic [WIDTH-1:0]     r_norm_mant;
    logic [EXP_W-1:0]     r_norm_exp;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // ------------------------------------------------------------------
    // Leading-one search: later (higher) hits overwrite, so the MSB wins
    // ------------------------------------------------------------------
    always_comb begin
        w_lead_pos = c_MSB_IDX;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_mant[i]) begin
                w_lead_pos = COUNT_W'(i);
            end
        end
    end

    assign w_in_zero = ~|in_mant;

    // ------------------------------------------------------------------
    // Stage 1: capture operands and leading-one index
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_exp   <= '0;
            r_s1_pos   <= c_MSB_IDX;
            r_s1_zero  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mant <= in_mant;
                r_s1_exp  <= in_exp;
                r_s1_pos  <= w_lead_pos;
                r_s1_zero <= w_in_zero;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: shift into the MSB and rebias the exponent
    // ------------------------------------------------------------------
    assign w_shift   = c_MSB_IDX - r_s1_pos;
    assign w_shifted = r_s1_mant << w_shift;
    assign w_exp_adj = r_s1_exp - EXP_W'(w_shift);

`ifdef FR_NORM_FTZ_EN
    logic w_uflow;
    logic r_underflow;

    assign w_uflow   = c_CMP_W'(r_s1_exp) < c_CMP_W'(w_shift);
    assign underflow = r_underflow;
`else
    assign underflow = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_count     <= c_MSB_IDX;
            r_zero      <= 1'b0;
            r_norm_mant <= '0;
            r_norm_exp  <= '0;
`ifdef FR_NORM_FTZ_EN
            r_underflow <= 1'b0;
`endif
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_count <= r_s1_pos;
                r_zero  <= r_s1_zero;
                if (r_s1_zero) begin
                    r_norm_mant <= '0;
                    r_norm_exp  <= '0;
`ifdef FR_NORM_FTZ_EN
                end else if (w_uflow) begin
                    r_norm_mant <= '0;
                    r_norm_exp  <= '0;
`endif
                end else begin
                    r_norm_mant <= w_shifted;
                    r_norm_exp  <= w_exp_adj;
                end
`ifdef FR_NORM_FTZ_EN
                // A zero mantissa applies no shift, so it can never underflow
                r_underflow <= w_uflow & ~r_s1_zero;
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign zero      = r_zero;
    assign norm_mant = r_norm_mant;
    assign norm_exp  = r_norm_exp;

endmodule
`default_nettype wire

// File: tb/tb_fr_normalize_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fr_normalize_pipe
//  Purpose  : Self-checking bench for fr_normalize_pipe (WIDTH=24).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fr_normalize_pipe;

    localparam int W  = 24;
    localparam int CW = 8;
    localparam int E  = 8;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          zero;
        logic [W-1:0]  nm;
        logic [E-1:0]  ne;
        logic          uf;
    } res_t;

    typedef struct {
        logic [W-1:0] m;
        logic [E-1:0] e;
        res_t         r;
    } vec_t;

    logic          clock = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_mant;
    logic [E-1:0]  in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          zero;
    logic [W-1:0]  norm_mant;
    logic [E-1:0]  norm_exp;
    logic          underflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    res_t exp_q[$];
    res_t out_log[$];
    int   acc_cyc[$];
    int   out_cyc[$];
    res_t held;
    res_t cur;
    logic held_v   = 1'b0;
    logic last_acc = 1'b0;

    fr_normalize_pipe #(.WIDTH(W), .COUNT_W(CW), .EXP_W(E)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .zero      (zero),
        .norm_mant (norm_mant),
        .norm_exp  (norm_exp),
        .underflow (underflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: scan from the MSB for the first one, then apply the rules arithmetically
    function automatic res_t model(input logic [W-1:0] m, input logic [E-1:0] e);
        res_t r;
        int   p;
        int   sh;
        int   ne;
        r = '0;
        if (m == '0) begin
            r.count = CW'(W - 1);
            r.zero  = 1'b1;
            return r;
        end
        p = W - 1;
        while (m[p] == 1'b0) p--;
        sh      = W - 1 - p;
        ne      = int'(e) - sh;
        r.count = CW'(p);
`ifdef FR_NORM_FTZ_EN
        if (ne < 0) begin
            r.uf = 1'b1;
            return r;
        end
`endif
        r.nm = m << sh;
        r.ne = E'(ne);
        return r;
    endfunction

    // Mid-cycle monitor: handshakes seen here complete on the next rising edge
    always @(negedge clock) begin
        if (!resetn) begin
            held_v   = 1'b0;
            last_acc = 1'b0;
        end else begin
            cur = {count, zero, norm_mant, norm_exp, underflow};
            if (held_v) check("hold_stable", {out_valid, cur}, {1'b1, held});
            held_v   = out_valid && !out_ready;
            held     = cur;
            last_acc = in_valid && in_ready;
            if (last_acc) begin
                exp_q.push_back(model(in_mant, in_exp));
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_with_nothing_in_flight", out_valid, 1'b0);
                else check("model_result", cur, exp_q.pop_front());
                out_log.push_back(cur);
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_all_delivered", exp_q.size(), 0);
    endtask

    vec_t tbl[8];
    res_t got;
    res_t bp_exp[4];
    int   idx;

    initial begin
        tbl[0] = '{24'h000100, 8'd20,  '{8'd8,  1'b0, 24'h800000, 8'd5,   1'b0}};
        tbl[1] = '{24'h000000, 8'd50,  '{8'd23, 1'b1, 24'h000000, 8'd0,   1'b0}};
`ifdef FR_NORM_FTZ_EN
        tbl[2] = '{24'h000001, 8'd10,  '{8'd0,  1'b0, 24'h000000, 8'd0,   1'b1}};
        tbl[7] = '{24'h000001, 8'd22,  '{8'd0,  1'b0, 24'h000000, 8'd0,   1'b1}};
`else
        tbl[2] = '{24'h000001, 8'd10,  '{8'd0,  1'b0, 24'h800000, 8'd243, 1'b0}};
        tbl[7] = '{24'h000001, 8'd22,  '{8'd0,  1'b0, 24'h800000, 8'd255, 1'b0}};
`endif
        tbl[3] = '{24'h800000, 8'd77,  '{8'd23, 1'b0, 24'h800000, 8'd77,  1'b0}};
        tbl[4] = '{24'hFFFFFF, 8'd0,   '{8'd23, 1'b0, 24'hFFFFFF, 8'd0,   1'b0}};
        tbl[5] = '{24'h000003, 8'd100, '{8'd1,  1'b0, 24'hC00000, 8'd78,  1'b0}};
        tbl[6] = '{24'h000001, 8'd23,  '{8'd0,  1'b0, 24'h800000, 8'd0,   1'b0}};

        bp_exp[0] = '{8'd22, 1'b0, 24'h800000, 8'd99,  1'b0};
        bp_exp[1] = '{8'd21, 1'b0, 24'h800000, 8'd98,  1'b0};
        bp_exp[2] = '{8'd23, 1'b0, 24'h800000, 8'd100, 1'b0};
        bp_exp[3] = '{8'd1,  1'b0, 24'hC00000, 8'd78,  1'b0};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_exp    = '0;
        out_ready = 1'b0;

        // Reset values
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        got = {count, zero, norm_mant, norm_exp, underflow};
        check("rst_outputs", {out_valid, got}, {1'b0, CW'(W - 1), 1'b0, {W{1'b0}}, {E{1'b0}}, 1'b0});
        tick();
        resetn = 1'b1;
        tick();

        // Directed vectors with latency check
        for (int v = 0; v < 8; v++) begin
            in_valid  = 1'b1;
            in_mant   = tbl[v].m;
            in_exp    = tbl[v].e;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_not_yet_valid", v), out_valid, 1'b0);
            tick();
            got = {count, zero, norm_mant, norm_exp, underflow};
            check($sformatf("vec%0d_result", v), {out_valid, got}, {1'b1, tbl[v].r});
            tick();
        end
        drain(10);

        // Backpressure: out_ready low for four cycles
        out_log.delete();
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        in_mant   = 24'h400000;
        in_exp    = 8'd100;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (last_acc && in_valid) begin
                idx++;
                case (idx)
                    1:       in_mant = 24'h200000;
                    2:       in_mant = 24'h800000;
                    3:       in_mant = 24'h000003;
                    default: in_valid = 1'b0;
                endcase
            end
            if (c == 3) begin
                check("bp_accepts_while_stalled", idx, 2);
                check("bp_in_ready_low", in_ready, 1'b0);
                out_ready = 1'b1;
            end
        end
        drain(10);
        check("bp_out_count", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            check($sformatf("bp_order%0d", i), out_log[i], bp_exp[i]);

        // Back-to-back throughput
        acc_cyc.delete();
        out_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_mant  = W'($urandom) >> $urandom_range(0, 24);
            in_exp   = E'($urandom);
            tick();
        end
        in_valid = 1'b0;
        drain(10);
        check("tp_accepts", acc_cyc.size(), 10);
        check("tp_outputs", out_cyc.size(), 10);
        if (acc_cyc.size() == 10 && out_cyc.size() == 10) begin
            check("tp_first_latency", out_cyc[0] - acc_cyc[0], 2);
            check("tp_consecutive_in", acc_cyc[9] - acc_cyc[0], 9);
            check("tp_consecutive_out", out_cyc[9] - out_cyc[0], 9);
        end

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_mant  = ($urandom_range(0, 15) == 0) ? '0 : (W'($urandom) >> $urandom_range(0, 23));
                in_exp   = E'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        drain(20);

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mant   = 24'h000100;
        in_exp    = 8'd20;
        tick();
        in_mant = 24'h000010;
        tick();
        in_valid = 1'b0;
        check("rst_mid_precond_valid", out_valid, 1'b1);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_count", count, CW'(W - 1));
        check("rst_mid_in_ready", in_ready, 1'b1);
        tick();
        resetn    = 1'b1;
        out_ready = 1'b1;
        idx       = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) idx++;
        end
        check("rst_no_stale_out", idx, 0);
        check("rst_after_in_ready", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
